// File: rtl/lx32_lsu.sv
// lx32 load/store unit: one data-memory transaction per op over req/gnt/rvalid,
// with store byte-lane replication and load sign/zero extension.
module lx32_lsu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             is_load,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             lsu_ready,
    output logic             lsu_done,
    output logic [WIDTH-1:0] lsu_result,
    output logic             lsu_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic             store_q, store_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] maddr_q, maddr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             bad_s;

    function automatic logic op_illegal(input logic ld, input logic st, input logic [2:0] f3);
        logic r;
        if (ld == st) begin
            r = 1'b1;
        end else if (ld) begin
            r = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end else begin
            r = (f3 > 3'd2);
        end
        return r;
    endfunction

    function automatic logic op_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic r;
        case (f3[1:0])
            2'd1:    r = off[0];
            2'd2:    r = (off != 2'd0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] store_lanes(input logic [2:0] f3, input logic [WIDTH-1:0] sd);
        logic [WIDTH-1:0] r;
        case (f3[1:0])
            2'd0:    r = {4{sd[7:0]}};
            2'd1:    r = {2{sd[15:0]}};
            default: r = sd;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] r;
        case (f3[1:0])
            2'd0:    r = 4'b0001 << off;
            2'd1:    r = 4'b0011 << off;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [WIDTH-1:0] rdata);
        logic [WIDTH-1:0] sh;
        logic [WIDTH-1:0] r;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'd0:    r = {{(WIDTH-8){sh[7]}}, sh[7:0]};
            3'd1:    r = {{(WIDTH-16){sh[15]}}, sh[15:0]};
            3'd4:    r = {{(WIDTH-8){1'b0}}, sh[7:0]};
            3'd5:    r = {{(WIDTH-16){1'b0}}, sh[15:0]};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign bad_s = op_illegal(is_load, is_store, funct3) || op_misaligned(funct3, addr[1:0]);

    // Next-state and datapath capture; responses are only consumed in REQ/WAIT.
    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        off_d    = off_q;
        store_d  = store_q;
        we_d     = we_q;
        maddr_d  = maddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (bad_s) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_REQ;
                        f3_d    = funct3;
                        off_d   = addr[1:0];
                        store_d = is_store;
                        we_d    = is_store;
                        maddr_d = {addr[WIDTH-1:2], 2'b00};
                        wdata_d = store_lanes(funct3, store_data);
                        wstrb_d = is_store ? store_strobe(funct3, addr[1:0]) : 4'b0000;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_gnt && mem_rvalid) begin
                    state_d  = S_DONE;
                    result_d = store_q ? {WIDTH{1'b0}} : load_extend(f3_q, off_q, mem_rdata);
                end else if (mem_gnt) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d  = S_DONE;
                    result_d = store_q ? {WIDTH{1'b0}} : load_extend(f3_q, off_q, mem_rdata);
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and request/result registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            f3_q     <= 3'd0;
            off_q    <= 2'd0;
            store_q  <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= {WIDTH{1'b0}};
            wdata_q  <= {WIDTH{1'b0}};
            wstrb_q  <= 4'b0000;
            result_q <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            store_q  <= store_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            result_q <= result_d;
        end
    end

    // Handshake outputs decode from state only, so reset drops mem_req immediately.
    assign lsu_ready  = (state_q == S_IDLE);
    assign lsu_done   = (state_q == S_DONE);
    assign lsu_err    = (state_q == S_ERR);
    assign mem_req    = (state_q == S_REQ);
    assign mem_we     = we_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
    assign lsu_result = result_q;

endmodule
